// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the serial pattern detector.
// Holds the FSM encoding, the reset-time defaults and the length check.
package seq_detector_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  // Reset configuration reproduces the classic overlapping "101" detector.
  localparam logic [7:0] DEF_PATTERN = 8'b0000_0101;
  localparam int         DEF_LEN     = 3;

  function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter.
// A clear together with an increment counts the new match, so the result is 1.
module seq_match_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// a registered match pulse and a saturating match counter.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int                 RST_LEN     = DEF_LEN,
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               x_valid,
  input  logic               x,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               cfg_err,
  output state_t             dbg_state,
  output logic [LW-1:0]      dbg_fill
);

  state_t             state_q;
  logic [MAX_LEN-1:0] hist_q, pat_q;
  logic [LW-1:0]      fill_q, len_q;
  logic               ovl_q, match_q;

  logic               accept, len_legal, hit;
  logic [MAX_LEN-1:0] hist_d, mask;
  logic [LW-1:0]      fill_d;

  // A bit arriving alongside cfg_load belongs to neither configuration.
  assign accept    = en && x_valid && !cfg_load;
  assign len_legal = len_ok(32'(len_q), MAX_LEN);
  assign hist_d    = {hist_q[MAX_LEN-2:0], x};
  assign fill_d    = (fill_q < len_q) ? fill_q + LW'(1) : fill_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len_q);
    end
  end

  assign hit = accept && (state_q != ST_ERR) && len_legal && (fill_d == len_q) &&
               (((hist_d ^ pat_q) & mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PATTERN;
      len_q   <= LW'(RST_LEN);
      ovl_q   <= 1'b1;
      match_q <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (cfg_load) begin
        pat_q   <= cfg_pattern;
        len_q   <= cfg_len;
        ovl_q   <= cfg_overlap;
        hist_q  <= '0;
        fill_q  <= '0;
        state_q <= len_ok(32'(cfg_len), MAX_LEN) ? ST_FILL : ST_ERR;
      end else if (accept && (state_q != ST_ERR)) begin
        if (hit) begin
          match_q <= 1'b1;
          if (ovl_q) begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= ST_ARMED;
          end else begin
            // Non-overlapping: the next match must be built from fresh bits.
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_FILL;
          end
        end else begin
          hist_q  <= hist_d;
          fill_q  <= fill_d;
          state_q <= (fill_d == len_q) ? ST_ARMED : ST_FILL;
        end
      end
    end
  end

  seq_match_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .inc_i   (hit),
    .count_o (match_count)
  );

  assign match     = match_q;
  assign armed     = (state_q == ST_ARMED);
  assign cfg_err   = (state_q == ST_ERR);
  assign dbg_state = state_q;
  assign dbg_fill  = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: expected match bits are queued as
// each stream bit is driven and popped once the registered pulse is visible.
module tb_seq_detector_param;
  import seq_detector_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic               clk, reset, en, cfg_load, cfg_overlap, cnt_clr, x_valid, x;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;

  logic          match, armed, cfg_err;
  logic [15:0]   match_count;
  state_t        dbg_state;
  logic [LW-1:0] dbg_fill;

  logic          match_c2, armed_c2, cfg_err_c2;
  logic [1:0]    match_count_c2;
  state_t        dbg_state_c2;
  logic [LW-1:0] dbg_fill_c2;

  logic exp_q[$];
  int   total = 0;
  int   bad   = 0;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .x_valid(x_valid), .x(x),
    .match(match), .match_count(match_count), .armed(armed), .cfg_err(cfg_err),
    .dbg_state(dbg_state), .dbg_fill(dbg_fill)
  );

  seq_detector_param #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .x_valid(x_valid), .x(x),
    .match(match_c2), .match_count(match_count_c2), .armed(armed_c2), .cfg_err(cfg_err_c2),
    .dbg_state(dbg_state_c2), .dbg_fill(dbg_fill_c2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop the expectation queued for the edge just taken.
  task automatic check_match();
    logic e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("match", 32'(match), 32'(e));
      chk("match_c2", 32'(match_c2), 32'(e));
    end
  endtask

  task automatic send(input logic b, input logic exp);
    x = b;
    x_valid = 1'b1;
    exp_q.push_back(exp);
    tick();
    x_valid = 1'b0;
    check_match();
  endtask

  // Sends n bits of 'bits' MSB first; 'exps' holds the matching expectations.
  task automatic send_bits(input logic [15:0] bits, input logic [15:0] exps, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], exps[i]);
  endtask

  task automatic idle(input int n);
    x_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(1'b0);
      tick();
      check_match();
    end
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [LW-1:0] len, input logic ov,
                     input logic clr);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    cnt_clr     = clr;
    x_valid     = 1'b0;
    tick();
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cnt_clr = 1'b0; x_valid = 1'b0; x = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_match", 32'(match), 0);
    chk("rst_count", 32'(match_count), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_FILL));
    chk("rst_fill", 32'(dbg_fill), 0);

    // Reset config "101" overlapping: 1,1,0,1,0,1,1
    send(1, 0); chk("armed_b1", 32'(armed), 0);
    send(1, 0); chk("armed_b2", 32'(armed), 0);
    send(0, 0); chk("armed_b3", 32'(armed), 1);
    send(1, 1); chk("armed_b4", 32'(armed), 1);
    send_bits(16'b011, 16'b010, 3);
    chk("t1_count", 32'(match_count), 2);
    chk("t1_count_c2", 32'(match_count_c2), 2);

    // "11" non-overlapping, then overlapping
    cfg(8'b11, 2, 0, 1);
    chk("t2_state", 32'(dbg_state), 32'(ST_FILL));
    chk("t2_fill", 32'(dbg_fill), 0);
    chk("t2_clr", 32'(match_count), 0);
    send_bits(16'b1111, 16'b0101, 4);
    chk("t2_count", 32'(match_count), 2);
    cfg(8'b11, 2, 1, 1);
    send_bits(16'b1111, 16'b0111, 4);
    chk("t2_ovl_count", 32'(match_count), 3);

    // Full-length pattern with an x_valid gap
    cfg(8'b1011_0010, 8, 1, 1);
    send_bits(16'b10110, 16'b00000, 5);
    idle(3);
    send_bits(16'b010, 16'b001, 3);
    chk("t3_count", 32'(match_count), 1);
    // Same pattern with en dropped mid-pattern
    cfg(8'b1011_0010, 8, 1, 0);
    send_bits(16'b101, 16'b000, 3);
    en = 1'b0;
    send(1, 0);
    send(1, 0);
    chk("t3_en_fill", 32'(dbg_fill), 3);
    en = 1'b1;
    send_bits(16'b10010, 16'b00001, 5);
    chk("t3_en_count", 32'(match_count), 2);

    // Illegal lengths
    cfg(8'h00, 0, 1, 0);
    chk("t4_err_len0", 32'(cfg_err), 1);
    chk("t4_state_len0", 32'(dbg_state), 32'(ST_ERR));
    send_bits(16'b001, 16'b000, 3);
    cfg(8'h05, 9, 1, 0);
    chk("t4_err_len9", 32'(cfg_err), 1);
    send_bits(16'b101101, 16'b000000, 6);
    cfg(8'h05, 3, 1, 0);
    chk("t4_err_clear", 32'(cfg_err), 0);
    chk("t4_state", 32'(dbg_state), 32'(ST_FILL));
    chk("t4_count", 32'(match_count), 2);

    // Saturation (CNT_W=2 instance) and clear priority
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_clr", 32'(match_count), 0);
    chk("t5_clr_c2", 32'(match_count_c2), 0);
    send_bits(16'b101_0101_0101, 16'b001_0101_0101, 11);
    chk("t5_count", 32'(match_count), 5);
    chk("t5_sat_c2", 32'(match_count_c2), 3);
    send(0, 0);
    cnt_clr = 1'b1;
    send(1, 1);
    cnt_clr = 1'b0;
    chk("t5_clr_hit", 32'(match_count), 1);
    chk("t5_clr_hit_c2", 32'(match_count_c2), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_clr_alone", 32'(match_count), 0);

    // Reset mid-stream restores "101"
    cfg(8'b110, 3, 1, 0);
    send_bits(16'b10, 16'b00, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_fill", 32'(dbg_fill), 0);
    send(1, 0);
    chk("t6_fill", 32'(dbg_fill), 1);
    chk("t6_armed", 32'(armed), 0);
    send_bits(16'b01, 16'b01, 2);
    chk("t6_count", 32'(match_count), 1);

    // Bit coincident with cfg_load is discarded
    cfg_pattern = 8'b101; cfg_len = 3; cfg_overlap = 1'b1;
    cfg_load = 1'b1; x_valid = 1'b1; x = 1'b1;
    exp_q.push_back(1'b0);
    tick();
    cfg_load = 1'b0; x_valid = 1'b0;
    check_match();
    chk("t6_load_fill", 32'(dbg_fill), 0);
    chk("t6_load_state", 32'(dbg_state), 32'(ST_FILL));
    send_bits(16'b01, 16'b00, 2);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
